sseg_bcd_feeder: RTL and testbench
==================================

Name: sseg_bcd_feeder

Overview:
Upstream stage of the 8-digit seven-segment scan controller. It converts a 32-bit binary value into 8 packed BCD digits using sequential double-dabble, one bit per clock. It applies leading-zero blanking with code 4'hF, which the digit decoder renders as blank. It also generates the free-running scan tick `tc_led`. Outputs `data` and `tc_led` connect directly to the scan controller's `data` and `tc_led` inputs.

Parameters:
REFRESH_DIV, 100000, scan tick period in clk cycles (≥2; 1 kHz digit rate at 100 MHz)
LZB, 1, 1 = blank leading zero digits 7..1 with 4'hF; 0 = show all digits

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
start  input  1  request conversion of `value`; sampled only in IDLE
value  input  32  unsigned binary value, captured on accepted start
busy  output  1  high while a conversion is in progress (state != IDLE)
done  output  1  one-cycle pulse; `data`/`ovf` updated in same cycle
data  output  32  8 BCD/blank nibbles, digit0 = data[3:0] … digit7 = data[31:28]; held between conversions
ovf  output  1  1 = last captured value > 99_999_999; held with `data`
tc_led  output  1  one-cycle scan tick every REFRESH_DIV cycles

Behaviour:
- All flops update on posedge clk. Reset is synchronous, active-high, and is sampled on the clock edge.
- Reset values: state=IDLE, busy=0, done=0, ovf=0, tc_led=0, tick counter=0, data=32'hFFFF_FFF0 if LZB=1 else 32'h0000_0000.
- Reset mid-conversion aborts the conversion; there is no partial update of `data`.
- FSM states: IDLE, CONV, FIN.
- IDLE:
  - On start=1 (edge E0): capture `value` into a 32-bit shift register and clear the 32-bit BCD accumulator.
  - Set ovf_pending = (value > 99_999_999), set bit counter = 0, go to CONV.
  - start=0: stay in IDLE.
- CONV, edges E1..E32, one per bit:
  - For each of the 8 accumulator nibbles, add 3 if the nibble is ≥5.
  - Then shift {accumulator, shift register} left by 1. The accumulator MSB shifted out is discarded.
  - Increment the counter. After the 32nd shift (counter==31), go to FIN.
- FIN (edge E33):
  - Load `data` from the accumulator, applying the blanking/overflow rules below, and set ovf = ovf_pending.
  - done=1 for exactly one cycle; go to IDLE.
- Latency is fixed at 33 edges from the start-sampling edge to done, including the overflow case.
- Blanking (LZB=1):
  - Digit k (k=7..1) becomes 4'hF if it and all higher digits are 0.
  - Digit 0 is never blanked.
  - LZB=0 outputs raw BCD.
- Overflow: if ovf_pending, data = 32'hFFFF_FFFE (digit0 shows 'E', others blank), regardless of LZB.
- `busy` is decoded from the state register (registered, glitch-free): 0 in IDLE, 1 in CONV/FIN.
- `start` while busy is ignored; no queueing.
- `start` in the cycle `done` is high is accepted, since the FSM is already in IDLE. Back-to-back conversions therefore take 34 cycles each.
- `value` is don't-care except on the accepting edge.
- Tick generator:
  - Counter width is clog2(REFRESH_DIV). It counts 0..REFRESH_DIV-1 and wraps to 0.
  - tc_led = 1 for the single cycle in which counter == REFRESH_DIV-1.
  - Free-running and independent of the conversion FSM; cleared only by reset.

Test Plan:
- Reset, LZB=1: check data=32'hFFFF_FFF0, busy=0, done=0, ovf=0, tc_led=0. Then start with value=12_345_678: busy=1 from next cycle, done pulses exactly 33 edges after acceptance, data=32'h1234_5678, ovf=0, busy=0 in done cycle.
- value=0 → data=32'hFFFF_FFF0. value=1000 → data=32'hFFFF_1000. Same with LZB=0: value=1000 → 32'h0000_1000.
- value=99_999_999 → data=32'h9999_9999, ovf=0. value=100_000_000 → data=32'hFFFF_FFFE, ovf=1. value=32'hFFFF_FFFF → data=32'hFFFF_FFFE, ovf=1, latency still 33.
- Conversion of 42:
  - Pulse start with value=7 at edge E10 of the conversion → ignored; result = 32'hFFFF_FF42.
  - Hold start=1 with value=5 through the done cycle → second conversion accepted there; next done 34 cycles after the first, data=32'hFFFF_FFF5.
- Assert reset at edge E20 of a conversion of 555 → busy=0 next cycle, data returns to the reset value, no done pulse ever issued for the aborted request.
- REFRESH_DIV=4: after reset release tc_led pulses at cycles 3, 7, 11… (1 of every 4). Pulses are unaffected by start/done activity. Reset mid-period restarts the count from 0.

Source files
------------

// File: rtl/sseg_bcd_feeder_if.sv
// Handshake and result bundle between a conversion requester and sseg_bcd_feeder.
// The scan controller taps data and tc_led from the same bundle.
interface sseg_bcd_feeder_if;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic [31:0] data;
  logic        ovf;
  logic        tc_led;

  modport master (
    output start,
    output value,
    input  busy,
    input  done,
    input  data,
    input  ovf,
    input  tc_led
  );

  modport slave (
    input  start,
    input  value,
    output busy,
    output done,
    output data,
    output ovf,
    output tc_led
  );
endinterface

// File: rtl/sseg_bcd_feeder.sv
// 32-bit binary to 8-digit BCD converter (sequential double-dabble, one bit per clock)
// with leading-zero blanking, overflow display and a free-running scan tick.
module sseg_bcd_feeder #(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZB         = 1'b1
) (
  input logic              clk,
  input logic              reset,
  sseg_bcd_feeder_if.slave bus
);
  localparam int          CW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [31:0] RESET_DATA = LZB ? 32'hFFFF_FFF0 : 32'h0000_0000;
  localparam logic [31:0] OVF_DATA   = 32'hFFFF_FFFE;
  localparam logic [31:0] BCD_MAX    = 32'd99_999_999;

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   data_q, data_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [31:0]   acc_adj;
  logic [31:0]   acc_blank;
  logic          all_zero;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = acc_q[gi*4 +: 4];
      assign acc_adj[gi*4 +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate

  // Walk from the most significant digit down; blank while everything above is zero.
  always_comb begin
    acc_blank = acc_q;
    all_zero  = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      all_zero = all_zero && (acc_q[k*4 +: 4] == 4'd0);
      if (LZB && all_zero) begin
        acc_blank[k*4 +: 4] = 4'hF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      data_q     <= RESET_DATA;
      bit_cnt_q  <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      tick_q     <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CONV;
      CONV:    if (bit_cnt_q == 5'd31) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    acc_d      = acc_q;
    data_d     = data_q;
    bit_cnt_d  = bit_cnt_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d    = bus.value;
          acc_d      = '0;
          bit_cnt_d  = '0;
          ovf_pend_d = (bus.value > BCD_MAX);
        end
      end
      CONV: begin
        acc_d     = {acc_adj[30:0], shift_q[31]};
        shift_d   = {shift_q[30:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
      FIN: begin
        data_d = ovf_pend_q ? OVF_DATA : acc_blank;
        ovf_d  = ovf_pend_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    tick_d = (tick_q == TICK_LAST) ? '0 : (tick_q + CW'(1));
  end

  always_comb begin
    bus.busy   = (state_q != IDLE);
    bus.done   = done_q;
    bus.data   = data_q;
    bus.ovf    = ovf_q;
    bus.tc_led = (tick_q == TICK_LAST);
  end
endmodule

// File: tb/tb_sseg_bcd_feeder.sv
// Bench for sseg_bcd_feeder: two instances (blanking on/off, different tick periods)
// share one stimulus stream and are compared every cycle against a decimal-arithmetic model.
module tb_sseg_bcd_feeder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = '0;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sseg_bcd_feeder_if bus1 ();
  sseg_bcd_feeder_if bus0 ();
  assign bus1.start = start;
  assign bus1.value = value;
  assign bus0.start = start;
  assign bus0.value = value;

  sseg_bcd_feeder #(.REFRESH_DIV(4), .LZB(1'b1)) dut1 (.clk(clk), .reset(rst), .bus(bus1.slave));
  sseg_bcd_feeder #(.REFRESH_DIV(5), .LZB(1'b0)) dut0 (.clk(clk), .reset(rst), .bus(bus0.slave));

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Expected display word from plain decimal arithmetic.
  function automatic logic [31:0] exp_word(logic [31:0] v, bit lzb);
    int unsigned x;
    int          dig[8];
    logic [31:0] w;
    bit          lead;
    if (v > 32'd99_999_999) return 32'hFFFF_FFFE;
    x = v;
    for (int k = 0; k < 8; k++) begin
      dig[k] = int'(x % 10);
      x      = x / 10;
    end
    w    = '0;
    lead = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      if (lzb && lead && k > 0 && dig[k] == 0) begin
        w[k*4 +: 4] = 4'hF;
      end else begin
        lead        = 1'b0;
        w[k*4 +: 4] = 4'(dig[k]);
      end
    end
    return w;
  endfunction

  // Model: a conversion is a 33-edge countdown; the result appears when it expires.
  int          m_remain;
  int          m_tcnt;
  logic [31:0] m_val, m_data1, m_data0;
  logic        m_ovf, m_done;

  always @(posedge clk) begin
    if (rst) begin
      m_remain = 0;
      m_done   = 1'b0;
      m_data1  = 32'hFFFF_FFF0;
      m_data0  = 32'h0;
      m_ovf    = 1'b0;
      m_tcnt   = 0;
    end else begin
      m_tcnt++;
      m_done = (m_remain == 1);
      if (m_remain > 0) begin
        m_remain--;
        if (m_remain == 0) begin
          m_data1 = exp_word(m_val, 1'b1);
          m_data0 = exp_word(m_val, 1'b0);
          m_ovf   = (m_val > 32'd99_999_999);
        end
      end else if (start) begin
        m_remain = 33;
        m_val    = value;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1 ("cyc_busy1", bus1.busy,   m_remain != 0);
      chk1 ("cyc_done1", bus1.done,   m_done);
      chk32("cyc_data1", bus1.data,   m_data1);
      chk1 ("cyc_ovf1",  bus1.ovf,    m_ovf);
      chk1 ("cyc_tick1", bus1.tc_led, (m_tcnt % 4) == 3);
      chk1 ("cyc_busy0", bus0.busy,   m_remain != 0);
      chk1 ("cyc_done0", bus0.done,   m_done);
      chk32("cyc_data0", bus0.data,   m_data0);
      chk1 ("cyc_ovf0",  bus0.ovf,    m_ovf);
      chk1 ("cyc_tick0", bus0.tc_led, (m_tcnt % 5) == 4);
    end
  end

  task automatic run_conv(logic [31:0] v, logic [31:0] lit1, logic [31:0] lit0, logic lit_ovf);
    int lat;
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1 start = 1'b0;
    value = $urandom;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) chk1("busy_after_accept", bus1.busy, 1'b1);
    end while (bus1.done !== 1'b1 && lat < 60);
    chk32("latency",      32'(lat), 32'd33);
    chk32("lit_data_lzb", bus1.data, lit1);
    chk32("lit_data_raw", bus0.data, lit0);
    chk1 ("lit_ovf",      bus1.ovf,  lit_ovf);
    chk1 ("busy_in_done", bus1.busy, 1'b0);
    $display("conv value=%0d data_lzb=%h data_raw=%h ovf=%b latency=%0d",
             v, bus1.data, bus0.data, bus1.ovf, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int gap;
    int pulses;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk32("rst_data_lzb", bus1.data, 32'hFFFF_FFF0);
    chk32("rst_data_raw", bus0.data, 32'h0000_0000);
    chk1 ("rst_busy",     bus1.busy, 1'b0);
    chk1 ("rst_done",     bus1.done, 1'b0);
    chk1 ("rst_ovf",      bus1.ovf,  1'b0);
    chk1 ("rst_tick",     bus1.tc_led, 1'b0);
    $display("reset data_lzb=%h data_raw=%h", bus1.data, bus0.data);

    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk1("tick_period4", bus1.tc_led, (i % 4) == 3);
    end
    $display("tick pattern after reset checked for 12 cycles");

    run_conv(32'd12_345_678,  32'h1234_5678, 32'h1234_5678, 1'b0);
    run_conv(32'd0,           32'hFFFF_FFF0, 32'h0000_0000, 1'b0);
    run_conv(32'd1000,        32'hFFFF_1000, 32'h0000_1000, 1'b0);
    run_conv(32'd99_999_999,  32'h9999_9999, 32'h9999_9999, 1'b0);
    run_conv(32'd100_000_000, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1);
    run_conv(32'hFFFF_FFFF,   32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1);

    // Conversion of 42 with an ignored start at E10 and a held start through done.
    @(negedge clk);
    start = 1'b1;
    value = 32'd42;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    value = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 start = 1'b1;
    value = 32'd5;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus1.done !== 1'b1 && n < 20);
    chk32("ignored_start_lzb", bus1.data, 32'hFFFF_FF42);
    chk32("ignored_start_raw", bus0.data, 32'h0000_0042);
    $display("conv value=42 with start at E10 data_lzb=%h", bus1.data);
    @(posedge clk);
    #1 start = 1'b0;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (bus1.done !== 1'b1 && gap < 60);
    chk32("back_to_back_gap", 32'(gap), 32'd34);
    chk32("back_to_back_lzb", bus1.data, 32'hFFFF_FFF5);
    chk32("back_to_back_raw", bus0.data, 32'h0000_0005);
    $display("back-to-back conv value=5 gap=%0d data_lzb=%h", gap, bus1.data);

    // Reset at E20 of a conversion of 555.
    @(negedge clk);
    start = 1'b1;
    value = 32'd555;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int m = 0; m < 40; m++) begin
      @(negedge clk);
      if (m == 0) begin
        chk1 ("abort_busy",     bus1.busy, 1'b0);
        chk32("abort_data_lzb", bus1.data, 32'hFFFF_FFF0);
        chk32("abort_data_raw", bus0.data, 32'h0000_0000);
      end
      chk1("abort_tick_restart", bus1.tc_led, (m % 4) == 3);
      if (bus1.done === 1'b1) pulses++;
    end
    chk32("abort_no_done", 32'(pulses), 32'd0);
    $display("abort at E20 value=555 done_pulses=%0d", pulses);

    // Random conversions, stray starts while busy and occasional resets.
    for (int t = 0; t < 40; t++) begin
      int sel;
      logic [31:0] v;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = $urandom_range(0, 999);
        1:       v = $urandom_range(0, 99_999_999);
        2:       v = $urandom;
        default: v = 32'd99_999_990 + $urandom_range(0, 20);
      endcase
      repeat ($urandom_range(0, 5)) @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      value = v;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      start = 1'b0;
      value = $urandom;
      if ($urandom_range(0, 14) == 0) begin
        repeat ($urandom_range(1, 25)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      for (int c = 0; c < 80 && m_remain != 0; c++) @(negedge clk);
      @(negedge clk);
      $display("rand %0d value=%0d data_lzb=%h data_raw=%h ovf=%b", t, v, bus1.data, bus0.data, bus1.ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
